vsync: RTL and testbench

//  Vertical timing stage fed by the horizontal timing generator's hsync/display_active.

---
 rtl/vsync_if.sv | 35 +++
 rtl/vsync.sv | 129 ++++++++++++
 tb/tb_vsync.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vsync_if.sv
// Vertical timing signal bundle: line-timing inputs in, frame-timing outputs back.
// Optional frame_start signal present only when VSYNC_FRAME_START_EN is defined.
interface vsync_if #(
  parameter int ROW_W = 7
);
  logic             hsync;
  logic             display_active;
  logic             vsync;
  logic [ROW_W-1:0] vPixel;
  logic             v_active;
  logic             video_on;
  logic [2:0]       state_dbg;
`ifdef VSYNC_FRAME_START_EN
  logic             frame_start;
`endif

  // master: the upstream line timing source / consumer; slave: the vsync block.
  // No valid/ready handshake: hsync falling edges are the only events, and
  // outputs are level signals sampled by the consumer every clock.
  modport master (
    output hsync, display_active,
    input  vsync, vPixel, v_active, video_on, state_dbg
`ifdef VSYNC_FRAME_START_EN
    , input frame_start
`endif
  );

  modport slave (
    input  hsync, display_active,
    output vsync, vPixel, v_active, video_on, state_dbg
`ifdef VSYNC_FRAME_START_EN
    , output frame_start
`endif
  );
endinterface

// File: rtl/vsync.sv
// Vertical timing stage: counts lines on hsync falling edges, drives vsync/vPixel/v_active.
// Define VSYNC_FRAME_START_EN to add the frame_start one-clock pulse output.
module vsync #(
  parameter int PULSE_LINES       = 2,
  parameter int BACK_PORCH_LINES  = 29,
  parameter int DISPLAY_LINES     = 480,
  parameter int FRONT_PORCH_LINES = 10,
  parameter int ROW_LINES         = 5,
  parameter int ROW_W             = 7
) (
  input  logic    clk,
  input  logic    reset,
  vsync_if.slave  vif
);
  localparam int TOTAL_LINES = PULSE_LINES + BACK_PORCH_LINES + DISPLAY_LINES + FRONT_PORCH_LINES;
  localparam int SUB_W       = (ROW_LINES > 1) ? $clog2(ROW_LINES) : 1;

  localparam logic [9:0]       PULSE_END = 10'(PULSE_LINES - 1);
  localparam logic [9:0]       BACK_END  = 10'(PULSE_LINES + BACK_PORCH_LINES - 1);
  localparam logic [9:0]       DISP_END  = 10'(PULSE_LINES + BACK_PORCH_LINES + DISPLAY_LINES - 1);
  localparam logic [9:0]       LAST_LINE = 10'(TOTAL_LINES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(ROW_LINES - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(DISPLAY_LINES / ROW_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_BACK  = 3'd2,
    S_DISP  = 3'd3,
    S_FRONT = 3'd4
  } state_t;

  state_t           state_q;
  logic [9:0]       line_cnt_q;
  logic [9:0]       line_cnt_d;
  logic [SUB_W-1:0] row_sub_q;
  logic [ROW_W-1:0] vpixel_q;
  logic             v_active_q;
  logic             vsync_q;
  logic             hsync_q;
  logic             line_tick;
`ifdef VSYNC_FRAME_START_EN
  logic             frame_start_q;
`endif

  // hsync_q resets high so an hsync already low at reset release counts as an edge.
  assign line_tick  = hsync_q & ~vif.hsync;
  assign line_cnt_d = (line_cnt_q == LAST_LINE) ? 10'd0 : line_cnt_q + 10'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      line_cnt_q    <= '0;
      row_sub_q     <= '0;
      vpixel_q      <= '0;
      v_active_q    <= 1'b0;
      vsync_q       <= 1'b1;
      hsync_q       <= 1'b1;
`ifdef VSYNC_FRAME_START_EN
      frame_start_q <= 1'b0;
`endif
    end else begin
      hsync_q       <= vif.hsync;
`ifdef VSYNC_FRAME_START_EN
      frame_start_q <= 1'b0;
`endif
      if (line_tick) begin
        line_cnt_q <= line_cnt_d;
        case (state_q)
          S_IDLE: begin
            state_q    <= S_PULSE;
            line_cnt_q <= '0;
            vsync_q    <= 1'b0;
`ifdef VSYNC_FRAME_START_EN
            frame_start_q <= 1'b1;
`endif
          end
          S_PULSE: begin
            if (line_cnt_q == PULSE_END) begin
              state_q <= S_BACK;
              vsync_q <= 1'b1;
            end
          end
          S_BACK: begin
            if (line_cnt_q == BACK_END) begin
              state_q    <= S_DISP;
              v_active_q <= 1'b1;
              vpixel_q   <= '0;
              row_sub_q  <= '0;
            end
          end
          S_DISP: begin
            // Leaving the last display line wins over the row step that coincides with it.
            if (line_cnt_q == DISP_END) begin
              state_q    <= S_FRONT;
              v_active_q <= 1'b0;
              vpixel_q   <= '0;
              row_sub_q  <= '0;
            end else if (row_sub_q == SUB_LAST) begin
              row_sub_q <= '0;
              if (vpixel_q != ROW_MAX) vpixel_q <= vpixel_q + 1'b1;
            end else begin
              row_sub_q <= row_sub_q + 1'b1;
            end
          end
          S_FRONT: begin
            if (line_cnt_q == LAST_LINE) begin
              state_q <= S_PULSE;
              vsync_q <= 1'b0;
`ifdef VSYNC_FRAME_START_EN
              frame_start_q <= 1'b1;
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign vif.vsync     = vsync_q;
  assign vif.vPixel    = vpixel_q;
  assign vif.v_active  = v_active_q;
  assign vif.video_on  = vif.display_active & v_active_q;
  assign vif.state_dbg = state_q;
`ifdef VSYNC_FRAME_START_EN
  assign vif.frame_start = frame_start_q;
`endif
endmodule

// File: tb/tb_vsync.sv
// Random-line-length bench for vsync: line-number model feeds a due-cycle scoreboard.
module tb_vsync;
  localparam int ROW_W = 7;
  localparam int TOTAL = 521;
  localparam int EW    = 42;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hsync = 1'b1;
  logic display_active = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  vsync_if #(.ROW_W(ROW_W)) vif();
  assign vif.hsync          = hsync;
  assign vif.display_active = display_active;

  vsync #(.ROW_W(ROW_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif.slave)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // entry layout: {due_cycle[41:10], frame_start[9], vsync[8], v_active[7], vPixel[6:0]}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur = {32'd0, 1'b0, 1'b1, 1'b0, 7'd0};

  int   k = 0;
  logic prev_h = 1'b1;
  logic in_reset = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Expected outputs after the tick that starts frame line (tick_no mod TOTAL).
  function automatic logic [EW-1:0] model_entry(input int tick_no, input int due);
    int         line;
    logic       act;
    logic [6:0] pix;
    line = tick_no % TOTAL;
    act  = (line >= 31) && (line <= 510);
    pix  = act ? 7'((line - 31) / 5) : 7'd0;
    return {32'(due), (line == 0), (line >= 2), act, pix};
  endfunction

  // driver: one call = one clock; inputs change #1 after posedge
  task automatic step(input logic r, input logic h, input logic da);
    reset = r;
    hsync = h;
    display_active = da;
    if (!r) begin
      if (!in_reset) begin
        exp_q.delete();
        exp_q.push_back({32'(cyc), 1'b0, 1'b1, 1'b0, 7'd0});
      end
      in_reset = 1'b1;
      prev_h   = 1'b1;
      k        = 0;
    end else begin
      in_reset = 1'b0;
      if (prev_h && !h) begin
        exp_q.push_back(model_entry(k, cyc + 1));
        k++;
      end
      prev_h = h;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input int len, input int low);
    for (int i = 0; i < len; i++)
      step(1'b1, (i >= low), (i >= low) ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // monitor: retire due expectations, compare every cycle away from the edge
  always @(negedge clk) begin
    logic popped;
    popped = 1'b0;
    while (exp_q.size() > 0 && int'(exp_q[0][41:10]) <= cyc) begin
      cur = exp_q.pop_front();
      popped = 1'b1;
    end
    check("vsync",    int'(vif.vsync),    int'(cur[8]));
    check("v_active", int'(vif.v_active), int'(cur[7]));
    check("vPixel",   int'(vif.vPixel),   int'(cur[6:0]));
    check("video_on", int'(vif.video_on), int'(display_active & cur[7]));
`ifdef VSYNC_FRAME_START_EN
    check("frame_start", int'(vif.frame_start), int'(popped & cur[9]));
`endif
  end

  initial begin
    // reset held with hsync toggling
    for (int i = 0; i < 500; i++)
      step(1'b0, (i % 7 >= 3), 1'($urandom_range(0, 1)));

    // release with hsync low, run past two full frames
    for (int l = 0; l < 2 * TOTAL + 3; l++)
      do_line($urandom_range(4, 9), $urandom_range(1, 2));

    // advance to display line 231 (vPixel 40), then reset mid-line
    for (int g = 0; g < TOTAL && ((k - 1) % TOTAL) != 231; g++)
      do_line($urandom_range(4, 9), $urandom_range(1, 2));
    check("vpix_before_reset", int'(vif.vPixel), 40);
    display_active = 1'b1;
    reset = 1'b0;
    #1;
    check("rst_vsync",    int'(vif.vsync),    1);
    check("rst_v_active", int'(vif.v_active), 0);
    check("rst_vPixel",   int'(vif.vPixel),   0);
    check("rst_video_on", int'(vif.video_on), 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);

    // release with hsync high: nothing happens until the next falling edge
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    for (int l = 0; l < TOTAL + 40; l++)
      do_line($urandom_range(4, 9), $urandom_range(1, 2));

    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    check("tick_count_restart", k, TOTAL + 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
